// File: rtl/stream_group_accumulator.sv
// Sums each consecutive group of Group input beats into one widened total and
// presents it on a valid/ready output held stable under back-pressure.
module stream_group_accumulator #(
    parameter int unsigned Width    = 8,
    parameter int unsigned Group    = 4,
    localparam int unsigned OutWidth = Width + $clog2(Group)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                up_valid_i,
    output logic                up_ready_o,
    input  logic [Width-1:0]    up_data_i,
    output logic                down_valid_o,
    input  logic                down_ready_i,
    output logic [OutWidth-1:0] down_data_o
);

    localparam int unsigned CntW = $clog2(Group);
    localparam logic [CntW-1:0] LastCnt = CntW'(Group - 1);

    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [OutWidth-1:0] acc_q, acc_d;
    logic [OutWidth-1:0] res_q, res_d;
    logic                res_valid_q, res_valid_d;

    logic                last_beat;
    logic                in_fire;
    logic                out_fire;
    logic [OutWidth-1:0] sum;

    assign last_beat = (cnt_q == LastCnt);
    // Only the final beat can stall; it may proceed if the result slot frees this cycle.
    assign up_ready_o = !last_beat || !res_valid_q || down_ready_i;
    assign in_fire    = up_valid_i && up_ready_o;
    assign out_fire   = res_valid_q && down_ready_i;
    assign sum        = acc_q + OutWidth'(up_data_i);

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        if (out_fire) begin
            res_valid_d = 1'b0;
        end
        if (in_fire) begin
            if (last_beat) begin
                res_d       = sum;
                res_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign down_valid_o = res_valid_q;
    assign down_data_o  = res_q;

endmodule

// File: tb/tb_stream_group_accumulator.sv
// Bench for stream_group_accumulator: queue-based reference model checked every
// cycle, directed scenarios pinned with literal totals, plus randomized traffic.
module tb_stream_group_accumulator;

    localparam int unsigned Width    = 8;
    localparam int unsigned Group    = 4;
    localparam int unsigned OutWidth = 10;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                up_valid_i;
    logic                up_ready_o;
    logic [Width-1:0]    up_data_i;
    logic                down_valid_o;
    logic                down_ready_i;
    logic [OutWidth-1:0] down_data_o;

    stream_group_accumulator #(
        .Width(Width),
        .Group(Group)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .up_valid_i  (up_valid_i),
        .up_ready_o  (up_ready_o),
        .up_data_i   (up_data_i),
        .down_valid_o(down_valid_o),
        .down_ready_i(down_ready_i),
        .down_data_o (down_data_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    // Reference model: beats of the open group, completed totals awaiting transfer.
    int grp[$];
    int pend[$];
    int last_res = 0;

    // Observed output transfers and their cycle numbers.
    int log_q[$];
    int logt_q[$];
    int ready_low = 0;
    int valid_cycles = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk_i) begin
        logic exp_ready;
        logic in_fire;
        logic out_fire;
        int total;
        cyc++;
        if (!rst_ni) begin
            grp.delete();
            pend.delete();
            last_res = 0;
            check("rst_down_valid", {31'd0, down_valid_o}, 32'd0);
            check("rst_down_data", {22'd0, down_data_o}, 32'd0);
            check("rst_up_ready", {31'd0, up_ready_o}, 32'd1);
        end else begin
            exp_ready = !(grp.size() == Group - 1 && pend.size() > 0 && !down_ready_i);
            check("up_ready", {31'd0, up_ready_o}, {31'd0, exp_ready});
            check("down_valid", {31'd0, down_valid_o}, (pend.size() > 0) ? 32'd1 : 32'd0);
            check("down_data", {22'd0, down_data_o}, last_res);
            if (down_valid_o && down_ready_i) begin
                log_q.push_back(int'(down_data_o));
                logt_q.push_back(cyc);
            end
            if (!up_ready_o) ready_low++;
            if (down_valid_o) valid_cycles++;

            out_fire = pend.size() > 0 && down_ready_i;
            in_fire  = up_valid_i && exp_ready;
            if (out_fire) void'(pend.pop_front());
            if (in_fire) begin
                grp.push_back(int'(up_data_i));
                if (grp.size() == Group) begin
                    total = 0;
                    foreach (grp[i]) total += grp[i];
                    pend.push_back(total);
                    last_res = total;
                    grp.delete();
                end
            end
            if (pend.size() > 1) check("model_overflow", pend.size(), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input int d);
        bit done = 0;
        up_valid_i = 1'b1;
        up_data_i  = d[Width-1:0];
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk_i);
            done = up_ready_o;
            tick();
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no handshake expected one within 50 cycles");
        end
        up_valid_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int vc0;
        int bad_gap;
        rst_ni       = 1'b0;
        up_valid_i   = 1'b0;
        up_data_i    = '0;
        down_ready_i = 1'b1;
        repeat (3) tick();
        rst_ni = 1'b1;
        repeat (10) tick();
        check("idle_down_valid", {31'd0, down_valid_o}, 32'd0);
        check("idle_up_ready", {31'd0, up_ready_o}, 32'd1);

        // Basic group 1+2+3+4.
        base = log_q.size();
        vc0  = valid_cycles;
        for (int i = 1; i <= 4; i++) send(i);
        repeat (3) tick();
        check("basic_count", log_q.size() - base, 32'd1);
        check("basic_sum", log_q[base], 32'd10);
        check("basic_valid_cycles", valid_cycles - vc0, 32'd1);

        // Max values without wrap.
        base = log_q.size();
        repeat (4) send(255);
        repeat (3) tick();
        check("max_sum", log_q[base], 32'd1020);

        // Back-pressure: second group's final beat must stall behind the held result.
        down_ready_i = 1'b0;
        base = log_q.size();
        repeat (4) send(1);
        repeat (3) send(2);
        up_valid_i = 1'b1;
        up_data_i  = 8'd2;
        repeat (3) tick();
        check("bp_up_ready_low", {31'd0, up_ready_o}, 32'd0);
        check("bp_down_valid", {31'd0, down_valid_o}, 32'd1);
        check("bp_down_data_held", {22'd0, down_data_o}, 32'd4);
        down_ready_i = 1'b1;
        tick();
        up_valid_i = 1'b0;
        repeat (4) tick();
        check("bp_count", log_q.size() - base, 32'd2);
        check("bp_first", log_q[base], 32'd4);
        check("bp_second", log_q[base + 1], 32'd8);

        // Reset with a pending result and a partial group.
        down_ready_i = 1'b0;
        repeat (4) send(9);
        send(5);
        send(6);
        rst_ni = 1'b0;
        tick();
        check("mid_rst_down_valid", {31'd0, down_valid_o}, 32'd0);
        rst_ni       = 1'b1;
        down_ready_i = 1'b1;
        base = log_q.size();
        repeat (2) tick();
        check("post_rst_no_output", log_q.size() - base, 32'd0);
        repeat (4) send(1);
        repeat (3) tick();
        check("post_rst_count", log_q.size() - base, 32'd1);
        check("post_rst_sum", log_q[base], 32'd4);

        // Streaming at full rate.
        base      = log_q.size();
        ready_low = 0;
        for (int i = 0; i < 400; i++) begin
            up_valid_i = 1'b1;
            up_data_i  = Width'($urandom_range(0, 255));
            tick();
        end
        up_valid_i = 1'b0;
        repeat (3) tick();
        check("stream_ready_low", ready_low, 32'd0);
        check("stream_count", log_q.size() - base, 32'd100);
        bad_gap = 0;
        for (int i = base + 1; i < log_q.size(); i++) begin
            if (logt_q[i] - logt_q[i - 1] != 4) bad_gap++;
        end
        check("stream_spacing", bad_gap, 32'd0);

        // Random valid gaps and back-pressure.
        for (int i = 0; i < 800; i++) begin
            up_valid_i   = ($urandom_range(0, 9) < 7);
            up_data_i    = Width'($urandom_range(0, 255));
            down_ready_i = ($urandom_range(0, 9) < 5);
            tick();
        end
        up_valid_i   = 1'b0;
        down_ready_i = 1'b1;
        repeat (5) tick();
        check("final_drained", {31'd0, down_valid_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
